fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage of the five-stage MIPS pipeline. Owns the program counter, drives the word address into the combinational instruction ROM, and captures the returned instruction into the IF/ID pipeline register. Handles hazard stalls, branch/jump redirects from ID (one delay slot, no flush), exception redirects, and fetch address-error detection. Keeps a count of instructions delivered to ID.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset
- IM_BASE, 32'h0000_3000, byte address of ROM word 0
- IM_WORDS, 4096, ROM depth in words; legal fetch range is [IM_BASE, IM_BASE+4*IM_WORDS)
- EXC_PC, 32'h0000_4180, exception handler entry

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- stall  in  1  hazard unit: hold PC and IF/ID
- redirect_valid  in  1  ID branch taken / jump
- redirect_target  in  32  next PC when redirect_valid
- exc_valid  in  1  exception/interrupt taken this cycle
- im_addr  out  32  byte address to instruction ROM (= pc_f)
- im_data  in  32  instruction word returned combinationally by ROM
- pc_f  out  32  current fetch PC
- ir_d  out  32  IF/ID instruction
- pc_d  out  32  IF/ID PC
- pc8_d  out  32  IF/ID PC+8 (link value)
- valid_d  out  1  IF/ID holds a real fetch
- adel_d  out  1  IF/ID fetch address error
- fetch_count  out  32  instructions delivered to ID since reset

## Operation
- im_addr = pc_f, combinational. ROM read is same-cycle; fetch_unit registers nothing on the ROM side.
- Address error (adel_f), combinational: pc_f[1:0] != 0, or pc_f < IM_BASE, or pc_f >= IM_BASE+4*IM_WORDS (33-bit compare, no wrap).
- Per-edge priority, highest first:
  - reset: pc_f <= RESET_PC; ir_d, pc_d, pc8_d <= 0; valid_d, adel_d <= 0; fetch_count <= 0.
  - exc_valid: pc_f <= EXC_PC; IF/ID cleared (ir_d=0, pc_d=0, pc8_d=0, valid_d=0, adel_d=0). Overrides stall and redirect.
  - stall: pc_f, IF/ID and fetch_count hold. redirect_valid ignored (ID re-asserts it when the stall releases).
  - otherwise load IF/ID: pc_d <= pc_f; pc8_d <= pc_f+8; valid_d <= 1; adel_d <= adel_f; ir_d <= adel_f ? 0 : im_data; fetch_count <= fetch_count+1 (wraps mod 2^32).
    - pc_f <= redirect_valid ? redirect_target : pc_f+4 (mod 2^32).
- Redirect never flushes IF/ID: the instruction fetched in the redirect cycle is the delay slot and is delivered.
- Misaligned/out-of-range redirect_target is accepted into pc_f; the error surfaces as adel_d on the next load.
- adel_d faults count in fetch_count (they occupy an ID slot).

## Timing
- Latency: im_data sampled in cycle N appears on ir_d after edge N.
- First edge after reset deasserts: ir_d = ROM[0], pc_d = 0x3000, pc_f = 0x3004, valid_d = 1.
- Redirect asserted in cycle N (no stall): pc_f = redirect_target after edge N; delay slot (pc_f+4 of the branch) on ir_d after edge N.
- Stall for k cycles: all outputs except im_data-derived combinational ones frozen k edges.
- Simultaneous exc_valid+stall+redirect_valid: exception behaviour only.
- reset mid-stall or mid-redirect: reset behaviour only.
- No combinational path from im_data to any output.

## Test plan
- Reset then 4 free-running cycles with ROM[0..3]=0x3C011234,0x34210001,0x00000000,0x1000FFFF -> ir_d follows in order, pc_d 0x3000..0x300C, pc8_d = pc_d+8, fetch_count = 4.
- Branch at 0x3008 asserts redirect_valid, target 0x3000 -> delay slot 0x300C delivered, next pc_d = 0x3000, no bubble.
- stall held 3 cycles with redirect_valid=1 -> pc_f, ir_d, fetch_count unchanged for 3 edges; redirect taken only on the first unstalled edge.
- redirect_target 0x3002 then 0x7000 -> adel_d=1, ir_d=0, valid_d=1 for each; fetch_count still increments.
- exc_valid with stall=1 and redirect_valid=1 -> pc_f=0x4180, valid_d=0, ir_d=0; following edge ir_d=ROM[(0x4180-0x3000)/4].
- reset asserted one cycle during a stall -> all outputs at reset values, pc_f=0x3000.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the instruction ROM and
// loads the IF/ID register, with stall, redirect, exception and address-error handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        exc_valid,
  output logic [31:0] im_addr,
  input  logic [31:0] im_data,
  output logic [31:0] pc_f,
  output logic [31:0] ir_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        valid_d,
  output logic        adel_d,
  output logic [31:0] fetch_count
);

  // Limit held in 33 bits so a ROM ending at 2^32 does not wrap to zero.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  logic adel_f;

  assign im_addr = pc_f;

  always_comb begin
    adel_f = (pc_f[1:0] != 2'b00)
          || ({1'b0, pc_f} <  {1'b0, IM_BASE})
          || ({1'b0, pc_f} >= IM_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f        <= RESET_PC;
      ir_d        <= '0;
      pc_d        <= '0;
      pc8_d       <= '0;
      valid_d     <= 1'b0;
      adel_d      <= 1'b0;
      fetch_count <= '0;
    end else if (exc_valid) begin
      pc_f    <= EXC_PC;
      ir_d    <= '0;
      pc_d    <= '0;
      pc8_d   <= '0;
      valid_d <= 1'b0;
      adel_d  <= 1'b0;
    end else if (!stall) begin
      // The word fetched alongside a redirect is the delay slot and is kept.
      pc_d        <= pc_f;
      pc8_d       <= pc_f + 32'd8;
      valid_d     <= 1'b1;
      adel_d      <= adel_f;
      ir_d        <= adel_f ? '0 : im_data;
      fetch_count <= fetch_count + 32'd1;
      pc_f        <= redirect_valid ? redirect_target : pc_f + 32'd4;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table of per-cycle stimulus with expected
// IF/ID state, routed through a scoreboard queue, plus a hand-written exception sequence.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, exc_valid;
  logic [31:0] redirect_target;
  logic [31:0] im_addr, im_data;
  logic [31:0] pc_f, ir_d, pc_d, pc8_d, fetch_count;
  logic        valid_d, adel_d;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(32'h0000_3000),
    .IM_BASE (32'h0000_3000),
    .IM_WORDS(4096),
    .EXC_PC  (32'h0000_4180)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .exc_valid      (exc_valid),
    .im_addr        (im_addr),
    .im_data        (im_data),
    .pc_f           (pc_f),
    .ir_d           (ir_d),
    .pc_d           (pc_d),
    .pc8_d          (pc8_d),
    .valid_d        (valid_d),
    .adel_d         (adel_d),
    .fetch_count    (fetch_count)
  );

  // ROM model: the four program words, every other address returns a tagged word
  always_comb begin
    case (im_addr)
      32'h0000_3000: im_data = 32'h3C01_1234;
      32'h0000_3004: im_data = 32'h3421_0001;
      32'h0000_3008: im_data = 32'h0000_0000;
      32'h0000_300C: im_data = 32'h1000_FFFF;
      default:       im_data = {16'hA5A5, im_addr[15:0]};
    endcase
  end

  typedef struct {
    logic        rst, stl, rdv, exc;
    logic [31:0] tgt;
    logic [31:0] e_pcf, e_ir, e_pcd;
    logic        e_val, e_adel;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  function automatic vec_t mk(input logic rst, input logic stl, input logic rdv,
                              input logic exc, input logic [31:0] tgt,
                              input logic [31:0] e_pcf, input logic [31:0] e_ir,
                              input logic [31:0] e_pcd, input logic e_val,
                              input logic e_adel, input logic [31:0] e_cnt);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdv = rdv; v.exc = exc; v.tgt = tgt;
    v.e_pcf = e_pcf; v.e_ir = e_ir; v.e_pcd = e_pcd;
    v.e_val = e_val; v.e_adel = e_adel; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset           = v.rst;
    stall           = v.stl;
    redirect_valid  = v.rdv;
    exc_valid       = v.exc;
    redirect_target = v.tgt;
  endtask

  task automatic compare_next(input int idx);
    vec_t e;
    string tag;
    if (exp_q.size() == 0) begin
      tests++; failed++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1 at step %0d", idx);
      return;
    end
    e = exp_q.pop_front();
    tag = $sformatf("v%0d", idx);
    check({tag, ".pc_f"},        pc_f,        e.e_pcf);
    check({tag, ".ir_d"},        ir_d,        e.e_ir);
    check({tag, ".pc_d"},        pc_d,        e.e_pcd);
    check({tag, ".pc8_d"},       pc8_d,       e.e_val ? e.e_pcd + 32'd8 : 32'd0);
    check({tag, ".valid_d"},     {31'd0, valid_d}, {31'd0, e.e_val});
    check({tag, ".adel_d"},      {31'd0, adel_d},  {31'd0, e.e_adel});
    check({tag, ".fetch_count"}, fetch_count, e.e_cnt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] %0d tests run, %0d failed", tests, failed + 1);
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; exc_valid = 1'b0;
    redirect_target = '0;

    //            rst stl rdv exc  target         pc_f           ir_d           pc_d           val adel cnt
    vecs.push_back(mk(1, 1, 1, 0, 32'h0000_3010, 32'h0000_3000, 32'h0,         32'h0,         0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         32'h0000_3000, 32'h0,         32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'h3C01_1234, 32'h0000_3000, 1, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_3008, 32'h3421_0001, 32'h0000_3004, 1, 0, 2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_300C, 32'h0000_0000, 32'h0000_3008, 1, 0, 3));
    // branch at 0x3008 in ID: delay slot 0x300C delivered, target next
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3000, 32'h0000_3000, 32'h1000_FFFF, 32'h0000_300C, 1, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_3004, 32'h3C01_1234, 32'h0000_3000, 1, 0, 5));
    // three stalled edges with a redirect pending
    vecs.push_back(mk(0, 1, 1, 0, 32'h0000_3010, 32'h0000_3004, 32'h3C01_1234, 32'h0000_3000, 1, 0, 5));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0000_3010, 32'h0000_3004, 32'h3C01_1234, 32'h0000_3000, 1, 0, 5));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0000_3010, 32'h0000_3004, 32'h3C01_1234, 32'h0000_3000, 1, 0, 5));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3010, 32'h0000_3010, 32'h3421_0001, 32'h0000_3004, 1, 0, 6));
    // misaligned, then out-of-range, then last legal word, then below base
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_3002, 32'h0000_3002, 32'hA5A5_3010, 32'h0000_3010, 1, 0, 7));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_7000, 32'h0000_7000, 32'h0,         32'h0000_3002, 1, 1, 8));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_6FFC, 32'h0000_6FFC, 32'h0,         32'h0000_7000, 1, 1, 9));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_7000, 32'hA5A5_6FFC, 32'h0000_6FFC, 1, 0, 10));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0000_2FFC, 32'h0000_2FFC, 32'h0,         32'h0000_7000, 1, 1, 11));
    // exception wins over stall and redirect
    vecs.push_back(mk(0, 1, 1, 1, 32'h0000_3000, 32'h0000_4180, 32'h0,         32'h0,         0, 0, 11));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_4184, 32'hA5A5_4180, 32'h0000_4180, 1, 0, 12));
    // reset during a stall
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,         32'h0000_4184, 32'hA5A5_4180, 32'h0000_4180, 1, 0, 12));
    vecs.push_back(mk(1, 1, 1, 0, 32'h0000_5000, 32'h0000_3000, 32'h0,         32'h0,         0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h3C01_1234, 32'h0000_3000, 1, 0, 1));
    // PC wraps mod 2^32; pc8_d wraps too
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0000, 32'h0,         32'hFFFF_FFFC, 1, 1, 2));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,         32'h0000_0004, 32'h0,         32'h0000_0000, 1, 1, 3));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      compare_next(i);
    end

    // Hand sequence: plain exception, then redirect on the very next edge
    @(negedge clk);
    exc_valid = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
    @(posedge clk); #1;
    check("exc.pc_f",    pc_f,        32'h0000_4180);
    check("exc.valid_d", {31'd0, valid_d}, 32'd0);
    check("exc.count",   fetch_count, 32'd3);
    @(negedge clk);
    exc_valid = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_3008;
    @(posedge clk); #1;
    check("exc2.pc_d",   pc_d,        32'h0000_4180);
    check("exc2.ir_d",   ir_d,        32'hA5A5_4180);
    check("exc2.pc_f",   pc_f,        32'h0000_3008);
    check("exc2.count",  fetch_count, 32'd4);
    @(negedge clk);
    redirect_valid = 1'b0;
    @(posedge clk); #1;
    check("exc3.ir_d",   ir_d,        32'h0000_0000);
    check("exc3.pc8_d",  pc8_d,       32'h0000_3010);
    check("exc3.adel_d", {31'd0, adel_d}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
